// File: rtl/div_unit_pkg.sv
// Shared EX-stage definitions for the divide unit: operation codes and FSM states.
package div_unit_pkg;

  localparam logic [1:0] FN_DIV  = 2'b00;
  localparam logic [1:0] FN_DIVU = 2'b01;
  localparam logic [1:0] FN_REM  = 2'b10;
  localparam logic [1:0] FN_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic logic fn_signed(input logic [1:0] fn);
    return !((fn == FN_DIVU) || (fn == FN_REMU));
  endfunction

  function automatic logic fn_rem(input logic [1:0] fn);
    return !((fn == FN_DIV) || (fn == FN_DIVU));
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, trial subtract, restore on borrow.
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_nxt,
  output logic             q_bit
);

  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   diff;

  always_comb begin
    trial   = {rem, msb};
    q_bit   = (trial >= {2'b00, dvs});
    diff    = trial[WIDTH:0] - {1'b0, dvs};
    rem_nxt = q_bit ? diff : trial[WIDTH:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit with start/busy/done handshake.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [1:0]       FUNCT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             op_rem, neg_q, neg_r;
  logic [WIDTH-1:0] quo, dvs;
  logic [WIDTH:0]   rem, rem_nxt;
  logic             q_bit;
  logic             div_zero, ovf, sgn, accept, special, fix;
  logic [WIDTH-1:0] special_res, quo_fix, rem_fix;

  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v, input logic en);
    return (en && (v < 0)) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic signed [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  assign sgn      = fn_signed(FUNCT);
  assign div_zero = (DATA2 == '0);
  assign ovf      = sgn && (DATA1 == {1'b1, {(WIDTH-1){1'b0}}}) && (DATA2 == '1);

  // Divide-by-zero returns all ones / dividend; signed overflow returns dividend / zero.
  always_comb begin
    if (fn_rem(FUNCT)) special_res = div_zero ? DATA1 : '0;
    else               special_res = div_zero ? '1 : DATA1;
  end

  assign quo_fix = neg_if(quo, neg_q);
  assign rem_fix = neg_if(rem[WIDTH-1:0], neg_r);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    BUSY      = (state != ST_IDLE);
    accept    = 1'b0;
    special   = 1'b0;
    fix       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          if (div_zero || ovf) special = 1'b1;
          else begin
            accept    = 1'b1;
            state_nxt = ST_CALC;
          end
        end
      end
      ST_CALC: if (cnt == LAST) state_nxt = ST_FIX;
      ST_FIX: begin
        fix       = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control and result: cleared by reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      DONE   <= 1'b0;
      RESULT <= '0;
      cnt    <= '0;
      op_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      DONE <= special | fix;
      if (special)  RESULT <= special_res;
      else if (fix) RESULT <= op_rem ? rem_fix : quo_fix;
      if (accept) begin
        cnt    <= '0;
        op_rem <= fn_rem(FUNCT);
        neg_q  <= sgn && (DATA1[WIDTH-1] ^ DATA2[WIDTH-1]);
        neg_r  <= sgn && DATA1[WIDTH-1];
      end else if (state == ST_CALC) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Iteration datapath: magnitudes loaded at start, one quotient bit per cycle
  always_ff @(posedge CLK) begin
    if (accept) begin
      quo <= abs_val(DATA1, sgn);
      dvs <= abs_val(DATA2, sgn);
      rem <= '0;
    end else if (state == ST_CALC) begin
      quo <= {quo[WIDTH-2:0], q_bit};
      rem <= rem_nxt;
    end
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .msb     (quo[WIDTH-1]),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic, special cases, handshake hazards and async reset.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET, START;
  logic [1:0]  FUNCT;
  logic [31:0] DATA1, DATA2;
  logic        BUSY, DONE;
  logic [31:0] RESULT;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  div_unit #(.WIDTH(32)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .FUNCT  (FUNCT),
    .DATA1  (DATA1),
    .DATA2  (DATA2),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RESULT (RESULT)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, req);
    end
  endtask

  // Drive a request; returns #1 after the edge that samples it.
  task automatic issue(input logic [1:0] f, input logic [31:0] d1, input logic [31:0] d2);
    FUNCT = f; DATA1 = d1; DATA2 = d2; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; FUNCT = ~f; DATA1 = ~d1; DATA2 = d2 + 32'd3;
  endtask

  // lat = edges after the START-sampling edge until DONE is seen (0 = that edge raised it).
  task automatic wait_done(output int lat, output bit gap);
    lat = 0; gap = 1'b0;
    while (!DONE && lat < 40) begin
      if (!BUSY) gap = 1'b1;
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  task automatic check_op(input string tag, input logic [1:0] f, input logic [31:0] d1,
                          input logic [31:0] d2, input int exp_lat, input logic [31:0] exp_res);
    int lat; bit gap;
    issue(f, d1, d2);
    wait_done(lat, gap);
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".res"}, RESULT, exp_res);
    chk({tag, ".busy_in_done"}, {31'd0, BUSY}, 32'd0);
    chk({tag, ".busy_gap"}, {31'd0, gap}, 32'd0);
    @(posedge CLK); #1;
    chk({tag, ".done_pulse"}, {31'd0, DONE}, 32'd0);
    chk({tag, ".hold"}, RESULT, exp_res);
  endtask

  initial begin
    int lat, l2, seen;
    bit gap;
    RESET = 1'b1; START = 1'b0; FUNCT = FN_DIV; DATA1 = '0; DATA2 = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset.busy", {31'd0, BUSY}, 32'd0);
    chk("reset.done", {31'd0, DONE}, 32'd0);
    chk("reset.result", RESULT, 32'd0);
    RESET = 1'b0;

    check_op("divu_100_7",  FN_DIVU, 32'd100, 32'd7, 33, 32'd14);
    check_op("remu_100_7",  FN_REMU, 32'd100, 32'd7, 33, 32'd2);
    check_op("div_m20_6",   FN_DIV,  32'hFFFF_FFEC, 32'd6, 33, 32'hFFFF_FFFD);
    check_op("rem_m20_6",   FN_REM,  32'hFFFF_FFEC, 32'd6, 33, 32'hFFFF_FFFE);
    check_op("div_7_m2",    FN_DIV,  32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD);
    check_op("rem_7_m2",    FN_REM,  32'd7, 32'hFFFF_FFFE, 33, 32'd1);
    check_op("div_min_2",   FN_DIV,  32'h8000_0000, 32'd2, 33, 32'hC000_0000);
    check_op("divu_max_1",  FN_DIVU, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF);
    check_op("divu_min_m1", FN_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0);
    check_op("div_by0",     FN_DIV,  32'h0000_1234, 32'd0, 0, 32'hFFFF_FFFF);
    check_op("remu_by0",    FN_REMU, 32'h0000_1234, 32'd0, 0, 32'h0000_1234);
    check_op("div_ovf",     FN_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
    check_op("rem_ovf",     FN_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0);

    // Second START at cycle 10 of a busy op must be ignored
    issue(FN_DIVU, 32'd1000, 32'd10);
    lat = 0;
    repeat (9) begin @(posedge CLK); #1; lat++; end
    START = 1'b1; FUNCT = FN_DIVU; DATA1 = 32'd5; DATA2 = 32'd1;
    @(posedge CLK); #1; lat++;
    START = 1'b0;
    chk("ignore.busy", {31'd0, BUSY}, 32'd1);
    wait_done(l2, gap);
    chk("ignore.lat", lat + l2, 33);
    chk("ignore.res", RESULT, 32'd100);
    @(posedge CLK); #1;
    chk("ignore.no_extra_op", {31'd0, BUSY}, 32'd0);

    // START in the DONE cycle is accepted
    issue(FN_DIVU, 32'd100, 32'd7);
    wait_done(lat, gap);
    chk("b2b.first_res", RESULT, 32'd14);
    issue(FN_REMU, 32'd100, 32'd7);
    chk("b2b.busy", {31'd0, BUSY}, 32'd1);
    chk("b2b.hold", RESULT, 32'd14);
    wait_done(lat, gap);
    chk("b2b.lat", lat, 33);
    chk("b2b.res", RESULT, 32'd2);
    @(posedge CLK); #1;

    // Asynchronous reset in the middle of an operation
    issue(FN_DIVU, 32'd1000, 32'd10);
    repeat (14) @(posedge CLK);
    #3;
    RESET = 1'b1;
    #1;
    chk("areset.busy", {31'd0, BUSY}, 32'd0);
    chk("areset.done", {31'd0, DONE}, 32'd0);
    chk("areset.result", RESULT, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge CLK); #1; if (DONE || BUSY) seen++; end
    chk("areset.no_done", seen, 0);
    check_op("after_reset", FN_DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle RV32M divide/remainder unit in the EX stage, beside the combinational ALU.
- Executes DIV, DIVU, REM and REMU with a start/busy/done handshake, so the pipeline can stall EX while a division is in flight.
- Uses a radix-2 restoring algorithm: one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand and result width in bits. The iteration count equals WIDTH.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  request pulse; sampled only while BUSY=0.
- FUNCT  input  2  operation: 00=DIV, 01=DIVU, 10=REM, 11=REMU.
- DATA1  input  WIDTH  dividend (rs1).
- DATA2  input  WIDTH  divisor (rs2).
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse; RESULT is valid in that cycle.
- RESULT  output  WIDTH  quotient or remainder, selected by FUNCT.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, BUSY=0, DONE=0, RESULT=0. An in-flight operation is discarded with no DONE pulse.
- States: IDLE, CALC, FIX.
- IDLE, START=1, special case (see below), at edge E0:
  - Special result is registered into RESULT.
  - DONE=1 for the cycle after E0.
  - State stays IDLE; BUSY stays 0.
- IDLE, START=1, normal case, at edge E0:
  - Latch FUNCT and operand signs.
  - Load |DATA1| and |DATA2|; signed ops only, unsigned ops load raw values.
  - Clear remainder; iteration count=0; BUSY=1; state=CALC.
- CALC, at edges E1..E32 (WIDTH iterations):
  - Shift {rem, dividend} left by 1.
  - Trial subtract the divisor from rem. If no borrow, keep the difference and set the quotient LSB to 1; otherwise restore rem and set the LSB to 0.
  - Count increments; after iteration WIDTH, state=FIX.
- FIX, at edge E33:
  - Quotient is negated if signed and sign(DATA1)≠sign(DATA2).
  - Remainder is negated if signed and DATA1 was negative.
  - RESULT takes the quotient for DIV/DIVU, the remainder for REM/REMU.
  - DONE=1 for one cycle; BUSY=0; state=IDLE.
- Latency: normal case, DONE is high in the cycle following E33 (33 cycles after the START edge). Special case, DONE is high in the cycle following E0.
- Special cases (RISC-V semantics):
  - Divisor=0: quotient=all ones (0xFFFFFFFF), remainder=DATA1, for both signed and unsigned.
  - Signed overflow, DATA1=0x80000000 and DATA2=0xFFFFFFFF with DIV/REM: quotient=0x80000000, remainder=0.
- Operand/START handling:
  - START while BUSY=1 is ignored.
  - DATA1, DATA2 and FUNCT may change after E0 without affecting the operation.
- RESULT holds its value until the next DONE; DONE is never high for two consecutive cycles.
- Back-to-back: START may be asserted in the DONE cycle (state is IDLE then); it is accepted at that edge.
- Arithmetic: internal remainder register is WIDTH+1 bits so the subtract borrow is captured. Absolute value of 0x80000000 is 0x80000000 read as unsigned.

Decomposition:
- FUNCT encodings (DIV/DIVU/REM/REMU) and state encodings go in the shared EX-stage define file, next to the ALU SELECT codes.
- One natural sub-module: div_step, a combinational single iteration.
  - Inputs: rem, dividend MSB, divisor.
  - Outputs: new rem, quotient bit.
  - Instantiated once inside the FSM.

Test Plan:
- DIVU 100/7: START=1 with FUNCT=01 → DONE after exactly 33 cycles, RESULT=14; BUSY high from E0 until the DONE cycle.
- DIV/REM, DATA1=-20 (0xFFFFFFEC), DATA2=6 → DIV gives RESULT=0xFFFFFFFD (-3); REM gives RESULT=0xFFFFFFFE (-2).
- Divide by zero, DATA1=0x1234 with DATA2=0, FUNCT=00 then FUNCT=11 → DONE one cycle after START, RESULT=0xFFFFFFFF then 0x1234; BUSY never asserted.
- Overflow, DATA1=0x80000000, DATA2=0xFFFFFFFF → DIV gives 0x80000000 and REM gives 0, each with 1-cycle latency.
- Handshake hazards:
  - Second START at cycle 10 of a busy DIVU is ignored; RESULT is unchanged.
  - START in the DONE cycle starts a new op, and its DONE follows 33 cycles later.
- RESET asserted at cycle 15 of an operation → BUSY, DONE and RESULT go to 0 immediately (asynchronously), with no DONE pulse afterwards; a new START after release gives a correct result.
